// File: rtl/pk_unpack_ctrl_if.sv
// Byte-in / coefficient-out stream bundle for pk_unpack_ctrl.
// slave = unpacker side, master = the producer of bytes and consumer of coefficients.
interface pk_unpack_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] coef_out;
  logic [1:0]  coef_poly;
  logic [7:0]  coef_idx;
  logic        coef_valid;
  logic        coef_ready;

  modport slave (
    input  in_data, in_valid, coef_ready,
    output in_ready, coef_out, coef_poly, coef_idx, coef_valid
  );

  modport master (
    output in_data, in_valid, coef_ready,
    input  in_ready, coef_out, coef_poly, coef_idx, coef_valid
  );
endinterface

// File: rtl/pk_unpack_ctrl.sv
// Kyber public-key unpacker: 12-bit t coefficients from packed triples, then the 32-byte rho seed.
// Define PK_MODCHECK_EN to flag any coefficient >= KYBER_Q on the sticky err_range output.
module pk_unpack_ctrl #(
  parameter int KYBER_K = 3,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  pk_unpack_ctrl_if.slave       bus,
  output logic [255:0]          rho,
  output logic                  busy,
  output logic                  done,
  output logic                  err_range
);
  localparam int TBYTES = 384 * KYBER_K;
  localparam int BCW    = $clog2(TBYTES);
  localparam logic [BCW-1:0] LAST_T    = BCW'(TBYTES - 1);
  localparam logic [7:0]     LAST_IDX  = 8'(KYBER_N - 1);
  localparam logic [1:0]     LAST_POLY = 2'(KYBER_K - 1);

  if (KYBER_Q < 1 || KYBER_Q > 4095) begin : g_bad_q
    $error("KYBER_Q must fit in a 12-bit coefficient");
  end

  typedef enum logic [1:0] {IDLE, T_LOAD, RHO_LOAD, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [BCW-1:0]  bcnt_q;
  logic [1:0]      phase_q;
  logic [7:0]      b0_q, b1_q;
  logic [255:0]    rho_q;
  logic [11:0]     coef_q;
  logic [1:0]      poly_q, npoly_q;
  logic [7:0]      idx_q, nidx_q;
  logic            cv_q;

  logic            in_rdy, acc, ld, st_go;
  logic [11:0]     ld_val;

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    done    = 1'b0;
    st_go   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        st_go   = 1'b1;
        state_d = T_LOAD;
      end
      T_LOAD: begin
        // the output slot is a single register, so bytes stall while it is occupied
        in_rdy = !cv_q || bus.coef_ready;
        if (bus.in_valid && in_rdy && bcnt_q == LAST_T) state_d = RHO_LOAD;
      end
      RHO_LOAD: begin
        in_rdy = 1'b1;
        if (bus.in_valid && bcnt_q[4:0] == 5'd31) state_d = FLUSH;
      end
      FLUSH: if (!cv_q) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc    = bus.in_valid && in_rdy;
  assign ld     = acc && (state_q == T_LOAD) && (phase_q != 2'd0);
  assign ld_val = (phase_q == 2'd1) ? {bus.in_data[3:0], b0_q} : {bus.in_data, b1_q[7:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      rho_q   <= '0;
      coef_q  <= '0;
      poly_q  <= '0;
      idx_q   <= '0;
      npoly_q <= '0;
      nidx_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      if (st_go) begin
        bcnt_q  <= '0;
        phase_q <= '0;
        rho_q   <= '0;
        npoly_q <= '0;
        nidx_q  <= '0;
      end else if (acc && state_q == T_LOAD) begin
        bcnt_q  <= (bcnt_q == LAST_T) ? '0 : bcnt_q + 1'b1;
        phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        if (phase_q == 2'd0) b0_q <= bus.in_data;
        if (phase_q == 2'd1) b1_q <= bus.in_data;
      end else if (acc && state_q == RHO_LOAD) begin
        rho_q[{bcnt_q[4:0], 3'b000} +: 8] <= bus.in_data;
        bcnt_q <= bcnt_q + 1'b1;
      end

      // a load takes priority over a drain, which gives back-to-back replacement
      if (ld) begin
        cv_q   <= 1'b1;
        coef_q <= ld_val;
        idx_q  <= nidx_q;
        poly_q <= npoly_q;
        if (nidx_q == LAST_IDX) begin
          nidx_q  <= '0;
          npoly_q <= (npoly_q == LAST_POLY) ? 2'd0 : npoly_q + 2'd1;
        end else begin
          nidx_q  <= nidx_q + 8'd1;
        end
      end else if (bus.coef_ready) begin
        cv_q <= 1'b0;
      end
    end
  end

`ifdef PK_MODCHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if (st_go)                            err_q <= 1'b0;
    else if (ld && ld_val >= 12'(KYBER_Q))     err_q <= 1'b1;
  end
  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

  assign bus.in_ready   = in_rdy;
  assign bus.coef_out   = coef_q;
  assign bus.coef_poly  = poly_q;
  assign bus.coef_idx   = idx_q;
  assign bus.coef_valid = cv_q;
  assign rho            = rho_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_pk_unpack_ctrl.sv
// Scoreboard bench for pk_unpack_ctrl: randomized keys, a triple-to-coefficient reference model,
// and a monitor that pops expected coefficients whenever the DUT hands one over.
module tb_pk_unpack_ctrl;
  localparam int NT = 1152;
  localparam int NB = 1184;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [255:0] rho;
  logic busy, done, err_range;

  pk_unpack_ctrl_if bus ();

  pk_unpack_ctrl #(.KYBER_K(3), .KYBER_N(256), .KYBER_Q(3329)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .rho(rho), .busy(busy), .done(done), .err_range(err_range)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  poly;
    logic [7:0]  idx;
    logic [11:0] c;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  key [NB];
  int          n_chk = 0, n_fail = 0;
  int          done_cnt = 0;
  int          rmode = 1;
  int          stall_left = 0;
  bit          stall_arm = 0;
  bit          in_t = 0;
  bit          dead = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Coefficient pair t of a key, straight from the 12-bit little-endian packing.
  function automatic int coef_of(input int k);
    int t = k / 2;
    int b0 = key[3*t], b1 = key[3*t+1], b2 = key[3*t+2];
    return (k % 2 == 0) ? (b0 + 256 * (b1 % 16)) : (b1 / 16 + 16 * b2);
  endfunction

  task automatic push_exp(input int i);
    exp_t e;
    int k;
    if (i >= NT || i % 3 == 0) return;
    k = 2 * (i / 3) + (i % 3) - 1;
    e.poly = 2'(k / 256);
    e.idx  = 8'(k % 256);
    e.c    = 12'(coef_of(k));
    q.push_back(e);
  endtask

  // coef_ready driver: 1 = always ready, 2 = random, 3 = one 10-cycle stall on the first coefficient
  initial begin
    bus.coef_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: bus.coef_ready = 1'b1;
        2: bus.coef_ready = ($urandom_range(99) < 60);
        3: begin
          if (stall_arm && bus.coef_valid) begin
            stall_left = 10;
            stall_arm  = 0;
          end
          if (stall_left > 0) begin
            bus.coef_ready = 1'b0;
            stall_left--;
          end else bus.coef_ready = 1'b1;
        end
        default: bus.coef_ready = 1'b0;
      endcase
    end
  end

  // monitor
  initial begin
    exp_t  e, prev;
    bit    prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall)
          chk("hold_stable", {bus.coef_valid, bus.coef_poly, bus.coef_idx, bus.coef_out}, {1'b1, prev});
        if (!busy) chk("idle_in_ready", bus.in_ready, 1'b0);
        if (in_t && bus.coef_valid && !bus.coef_ready) chk("stall_in_ready", bus.in_ready, 1'b0);
        if (bus.coef_valid && bus.coef_ready) begin
          if (q.size() == 0) chk("sb_unexpected_coef", 1'b1, 1'b0);
          else begin
            e = q.pop_front();
            chk("coef", {bus.coef_poly, bus.coef_idx, bus.coef_out}, e);
          end
        end
        prev_stall = bus.coef_valid && !bus.coef_ready;
        prev = {bus.coef_poly, bus.coef_idx, bus.coef_out};
        if (done) done_cnt++;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_coef"}, {bus.coef_valid, bus.coef_out, bus.coef_poly, bus.coef_idx}, '0);
    chk({tag, "_rho"}, rho, '0);
    chk({tag, "_status"}, {busy, done, err_range}, 3'b000);
  endtask

  task automatic run_key(input int gap_pct, input int start_at, input int abort_at, input bit lat_chk);
    bit           err_exp, acc;
    logic [255:0] rho_exp;
    int           d0, waitn;
    if (dead) return;
    err_exp = 0;
    for (int k = 0; k < 768; k++) if (coef_of(k) >= 3329) err_exp = 1;
`ifndef PK_MODCHECK_EN
    err_exp = 0;
`endif
    for (int j = 0; j < 32; j++) rho_exp[8*j +: 8] = key[NT + j];
    stall_arm = 1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("start_clears", {err_range, rho}, '0);
    for (int i = 0; i < NB; i++) begin
      if (i == abort_at) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        in_t = 0;
        #1 chk_zero("mid_reset");
        q.delete();
        @(negedge clk);
        chk_zero("mid_reset_hold");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      while ($urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
      in_t = (i < NT);
      bus.in_data  = key[i];
      bus.in_valid = 1'b1;
      if (i == start_at) start = 1'b1;
      acc = 0;
      waitn = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.in_ready;
        if (acc) push_exp(i);
        @(posedge clk); #1;
        start = 1'b0;
        waitn++;
        if (!acc && waitn > 200) begin
          chk("byte_accept_timeout", 1'b0, 1'b1);
          dead = 1;
          bus.in_valid = 1'b0;
          return;
        end
      end
      bus.in_valid = 1'b0;
      if (lat_chk && i == 1) chk("first_coef_latency", {bus.coef_valid, bus.coef_out}, {1'b1, 12'h301});
      if (lat_chk && i == 2) chk("second_coef_latency", {bus.coef_valid, bus.coef_out}, {1'b1, 12'h452});
    end
    in_t = 0;
    waitn = 0;
    while (done_cnt == d0 && waitn < 3000) begin @(posedge clk); waitn++; end
    if (done_cnt == d0) begin
      chk("done_timeout", 1'b0, 1'b1);
      dead = 1;
      return;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 1'b0);
    chk("sb_drained", q.size(), 0);
    chk("rho", rho, rho_exp);
    chk("err_range", err_range, err_exp);
  endtask

  task automatic fill_key(input int first_mode);
    for (int i = 0; i < NT; i++) key[i] = 8'($urandom_range(255));
    if (first_mode == 1) begin key[0] = 8'h01; key[1] = 8'h23; key[2] = 8'h45; end
    if (first_mode == 2) begin key[0] = 8'hFF; key[1] = 8'hFF; key[2] = 8'hFF; end
    for (int j = 0; j < 32; j++) key[NT + j] = 8'(j);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    rmode = 1; fill_key(1);
    run_key(0, -1, -1, 1);

    rmode = 3; fill_key(0);
    for (int j = 0; j < 32; j++) key[NT + j] = 8'($urandom_range(255));
    run_key(0, -1, -1, 0);

    rmode = 2; fill_key(2);
    run_key(30, 300, -1, 0);

    rmode = 2; fill_key(0);
    run_key(20, -1, 500, 0);
    rmode = 1; fill_key(1);
    run_key(0, -1, -1, 1);

    rmode = 2; fill_key(0);
    for (int j = 0; j < 32; j++) key[NT + j] = 8'($urandom_range(255));
    run_key(10, 700, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pk_unpack_ctrl.md
PK_UNPACK_CTRL -- requirements
Module: pk_unpack_ctrl

Interface
REQ-001 SHALL have parameter KYBER_K, default 3, number of t polynomials.
REQ-002 SHALL have parameter KYBER_N, default 256, coefficients per polynomial.
REQ-003 SHALL have parameter KYBER_Q, default 3329, modulus for the range check.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin unpacking one public key.
REQ-007 SHALL have ports in_data  input  8, in_valid  input  1 and in_ready  output  1, which form the public-key byte stream.
REQ-008 SHALL have ports coef_out  output  12, coef_poly  output  2, coef_idx  output  8, coef_valid  output  1 and coef_ready  input  1, which form the coefficient stream.
REQ-009 SHALL have port rho  output  256  seed; the first rho byte sits at rho[7:0].
REQ-010 SHALL have ports busy  output  1, done  output  1 (single-cycle pulse) and err_range  output  1 (sticky).

Function
REQ-011 SHALL accept the byte order 384*KYBER_K t bytes, then 32 rho bytes; a byte transfers when in_valid && in_ready.
REQ-012 SHALL implement the states IDLE, T_LOAD, RHO_LOAD and FLUSH.
REQ-013 IDLE: on start, clear the byte counter, the phase counter, rho and err_range, then go to T_LOAD. start SHALL be ignored in every other state.
REQ-014 T_LOAD: in_ready = !coef_valid || coef_ready. Phase 0 latches b0; phase 1 latches b1; phase 2 latches b2. The phase counter SHALL wrap 2->0.
REQ-015 Accepting a phase-1 byte SHALL register coef_out = {b1[3:0], b0} with coef_valid=1 on the next cycle.
REQ-016 Accepting a phase-2 byte SHALL register coef_out = {b2, b1[7:4]} with coef_valid=1 on the next cycle.
REQ-017 coef_valid SHALL stay high and coef_out/coef_poly/coef_idx SHALL stay stable until coef_ready is sampled high. A load and a drain in the same cycle SHALL replace the entry with no bubble.
REQ-018 coef_idx SHALL count 0..KYBER_N-1 per polynomial, then wrap to 0 and increment coef_poly; coef_poly SHALL never exceed KYBER_K-1.
REQ-019 After the last t byte is accepted, the block SHALL go to RHO_LOAD. RHO_LOAD: in_ready=1 and byte j is written to rho[8j+7:8j].
REQ-020 After rho byte 31 is accepted, the block SHALL go to FLUSH. FLUSH: in_ready=0. When coef_valid==0, the block SHALL pulse done for 1 cycle and return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE. in_ready SHALL be 0 in IDLE.
REQ-022 rho SHALL hold its value from done until the next start.

Reset
REQ-023 On rst_n low, the block SHALL immediately enter IDLE and drive in_ready=0, coef_valid=0, coef_out=0, coef_poly=0, coef_idx=0, rho=0, busy=0, done=0, err_range=0.
REQ-024 Reset asserted mid-operation SHALL abandon the key; partial rho and pending coefficients SHALL be discarded.

Configuration
REQ-025 When PK_MODCHECK_EN is defined, err_range SHALL be set in the cycle a coefficient >= KYBER_Q is registered and SHALL stay set until start or reset; the coefficient SHALL still be emitted unchanged.
REQ-026 When PK_MODCHECK_EN is undefined, err_range SHALL be tied to 0 and no comparator SHALL exist.

Verification
REQ-027 Bytes 0x01,0x23,0x45 as the first triple with coef_ready=1 -> coef_out 0x301 (poly0, idx0), then 0x452 (poly0, idx1), each 1 cycle after its byte.
REQ-028 Full key of 1184 bytes with rho bytes 0x00..0x1F and coef_ready=1 -> 768 coefficients with coef_poly/idx sequencing 0/0..2/255, rho[7:0]=0x00, rho[255:248]=0x1F, a single done pulse, busy=0 afterwards.
REQ-029 coef_ready held 0 for 10 cycles after the first coefficient -> coef_valid and data stable, in_ready=0, no byte lost; back-to-back transfers resume with no bubble.
REQ-030 Triple 0xFF,0xFF,0xFF with PK_MODCHECK_EN defined -> coef 0xFFF, err_range=1 until the next start; with the macro undefined -> err_range stays 0.
REQ-031 rst_n pulsed low after byte 500, then a new start and a full key -> outputs zero during reset; the second key decodes exactly as in REQ-028.
REQ-032 start pulsed during T_LOAD -> ignored; counters and output stream unaffected.
